// File: rtl/am_envelope_decim_if.sv
//------------------------------------------------------------------------------
// am_envelope_decim_if
//
// Purpose:
//   Bundles the sample input and the audio/telemetry outputs of the AM
//   envelope detector/decimator. It carries no clock or reset; those stay
//   plain ports on the design.
//
// Signals:
//   if_filt_in   signed 8-bit IF filter output sample
//   sample_en    qualifier; if_filt_in is consumed only while high
//   audio_out    signed DC-removed envelope, held between strobes
//   audio_valid  one-clock strobe when audio_out updates
//   env_out      unsigned raw envelope of the last completed block
//   peak_out     max |sample| over the last completed block
//   overload     last completed block contained -128 or +127
//
// Modports:
//   master  sample source / audio sink (drives samples, observes outputs)
//   slave   the detector itself
//------------------------------------------------------------------------------
interface am_envelope_decim_if #(
    parameter int OUT_W = 10
);
    logic signed [7:0]       if_filt_in;
    logic                    sample_en;
    logic signed [OUT_W-1:0] audio_out;
    logic                    audio_valid;
    logic [OUT_W-1:0]        env_out;
    logic [6:0]              peak_out;
    logic                    overload;

    modport master (
        output if_filt_in,
        output sample_en,
        input  audio_out,
        input  audio_valid,
        input  env_out,
        input  peak_out,
        input  overload
    );

    modport slave (
        input  if_filt_in,
        input  sample_en,
        output audio_out,
        output audio_valid,
        output env_out,
        output peak_out,
        output overload
    );
endinterface

// File: rtl/am_envelope_decim.sv
//------------------------------------------------------------------------------
// am_envelope_decim
//
// Purpose:
//   AM envelope detector and decimator fed by the 455 kHz IF filter.
//   Every enabled clock one signed 8-bit sample is full-wave rectified and
//   summed into a boxcar integrator over N = 2**DECIM_LOG2 samples. At the
//   end of each block the top OUT_W bits of the sum form the raw envelope,
//   which then passes through a single-pole DC tracker so that the carrier
//   level is removed and only the audio modulation remains. Per-block peak
//   and overload flags are published for gain/AGC telemetry.
//
// Parameters:
//   DECIM_LOG2  log2 of the decimation ratio (N >= 2 so the output stage can
//               never be overrun by the next block)
//   OUT_W       envelope/audio width, 2 <= OUT_W <= 7+DECIM_LOG2
//   DC_SHIFT    DC tracker pole: dc_acc += env - (dc_acc >> DC_SHIFT)
//
// Ports:
//   clk   system clock, same domain as the IF filter
//   RSTb  asynchronous reset, active low; clears every register and output
//   bus   am_envelope_decim_if.slave (samples in, audio/telemetry out)
//
// Timing:
//   edge T   : terminal sample of a block accepted; env_out, peak_out and
//              overload take the block values
//   edge T+1 : output stage runs; audio_out updates with audio_valid high
//              for exactly one clock
//------------------------------------------------------------------------------
module am_envelope_decim #(
    parameter int DECIM_LOG2 = 8,
    parameter int OUT_W      = 10,
    parameter int DC_SHIFT   = 6
) (
    input  logic                clk,
    input  logic                RSTb,
    am_envelope_decim_if.slave  bus
);

    localparam int ACC_W = 7 + DECIM_LOG2;
    localparam int DC_W  = OUT_W + DC_SHIFT;

    localparam logic [DECIM_LOG2-1:0] CNT_LAST = '1;
    localparam logic [DECIM_LOG2-1:0] CNT_ONE  = {{(DECIM_LOG2-1){1'b0}}, 1'b1};

    localparam logic signed [OUT_W-1:0] AUDIO_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] AUDIO_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    //--------------------------------------------------------------------------
    // Rectifier
    //--------------------------------------------------------------------------
    logic [7:0] in_raw;
    logic [6:0] neg_lo;
    logic [6:0] mag;
    logic       ovl_hit;

    assign in_raw = bus.if_filt_in;
    // Low 7 bits of the two's-complement negation; only -128 needs the top
    // bit, and that case saturates instead.
    assign neg_lo = ~in_raw[6:0] + 7'd1;

    always_comb begin
        mag = in_raw[6:0];
        if (in_raw[7]) begin
            if (in_raw == 8'h80) begin
                mag = 7'd127;
            end else begin
                mag = neg_lo;
            end
        end
    end

    assign ovl_hit = (in_raw == 8'h80) || (in_raw == 8'h7F);

    //--------------------------------------------------------------------------
    // Block integrator and block telemetry
    //--------------------------------------------------------------------------
    logic [DECIM_LOG2-1:0] cnt;
    logic [ACC_W-1:0]      acc;
    logic [ACC_W-1:0]      sum;
    logic [6:0]            blk_peak;
    logic [6:0]            peak_next;
    logic                  blk_ovl;
    logic                  ovl_next;
    logic                  last_smp;
    logic [OUT_W-1:0]      env_new;

    logic [OUT_W-1:0]      env_r;
    logic [OUT_W-1:0]      env_q;
    logic [6:0]            peak_q;
    logic                  ovl_q;
    logic                  stage_v;

    // N*127 < 2**ACC_W, so the block sum never wraps.
    assign sum       = acc + {{DECIM_LOG2{1'b0}}, mag};
    assign env_new   = sum[ACC_W-1 -: OUT_W];
    assign peak_next = (mag > blk_peak) ? mag : blk_peak;
    assign ovl_next  = blk_ovl | ovl_hit;
    assign last_smp  = bus.sample_en && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge RSTb) begin
        if (!RSTb) begin
            cnt      <= '0;
            acc      <= '0;
            blk_peak <= '0;
            blk_ovl  <= 1'b0;
            env_r    <= '0;
            env_q    <= '0;
            peak_q   <= '0;
            ovl_q    <= 1'b0;
        end else if (bus.sample_en) begin
            if (cnt == CNT_LAST) begin
                // The terminal sample is folded into the published block
                // values, and the next block starts from zero on the
                // following enabled sample.
                cnt      <= '0;
                acc      <= '0;
                blk_peak <= '0;
                blk_ovl  <= 1'b0;
                env_r    <= env_new;
                env_q    <= env_new;
                peak_q   <= peak_next;
                ovl_q    <= ovl_next;
            end else begin
                cnt      <= cnt + CNT_ONE;
                acc      <= sum;
                blk_peak <= peak_next;
                blk_ovl  <= ovl_next;
            end
        end
    end

    // The output stage runs independently of sample_en so a stalled sample
    // stream cannot delay a finished block.
    always_ff @(posedge clk or negedge RSTb) begin
        if (!RSTb) begin
            stage_v <= 1'b0;
        end else begin
            stage_v <= last_smp;
        end
    end

    //--------------------------------------------------------------------------
    // DC tracker and audio output
    //--------------------------------------------------------------------------
    logic [DC_W-1:0]          dc_acc;
    logic [OUT_W-1:0]         dc_est;
    logic [DC_W-1:0]          dc_next;
    logic signed [OUT_W:0]    diff;
    logic signed [OUT_W-1:0]  diff_sat;
    logic signed [OUT_W-1:0]  audio_r;
    logic                     valid_r;

    assign dc_est = dc_acc[DC_W-1:DC_SHIFT];

    // dc_acc settles at env << DC_SHIFT, so the true result always fits in
    // DC_W bits and modular arithmetic at that width is exact.
    assign dc_next = dc_acc
                   + {{DC_SHIFT{1'b0}}, env_r}
                   - {{DC_SHIFT{1'b0}}, dc_est};

    // Both operands are unsigned OUT_W, so one extra bit holds any difference.
    assign diff = $signed({1'b0, env_r}) - $signed({1'b0, dc_est});

    always_comb begin
        diff_sat = diff[OUT_W-1:0];
        if (diff[OUT_W] != diff[OUT_W-1]) begin
            diff_sat = diff[OUT_W] ? AUDIO_MIN : AUDIO_MAX;
        end
    end

    always_ff @(posedge clk or negedge RSTb) begin
        if (!RSTb) begin
            dc_acc  <= '0;
            audio_r <= '0;
            valid_r <= 1'b0;
        end else begin
            valid_r <= stage_v;
            if (stage_v) begin
                audio_r <= diff_sat;
                dc_acc  <= dc_next;
            end
        end
    end

    assign bus.audio_out   = audio_r;
    assign bus.audio_valid = valid_r;
    assign bus.env_out     = env_q;
    assign bus.peak_out    = peak_q;
    assign bus.overload    = ovl_q;

endmodule
